// File: rtl/con_bus_scheduler_if.sv
// Host connection bus bundle: ODS write side, controller load handshake and
// outbound host handshake, grouped so the scheduler takes a single port.
interface con_bus_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [31:0]           wr_x, wr_y, wr_ch;
  logic                  load_req;
  logic                  load_gnt;
  logic                  host_out_valid;
  logic                  host_out_ready;
  logic [DATA_WIDTH-1:0] host_out_data;
  logic [31:0]           host_out_x, host_out_y, host_out_ch;
  logic                  driving_cons;
  logic                  stall_req;
  logic [CW-1:0]         fifo_count;
  logic                  overflow;

  modport master (
    input  wr_valid, wr_data, wr_x, wr_y, wr_ch, load_req, host_out_ready,
    output load_gnt, host_out_valid, host_out_data, host_out_x, host_out_y,
           host_out_ch, driving_cons, stall_req, fifo_count, overflow
  );

  modport slave (
    output wr_valid, wr_data, wr_x, wr_y, wr_ch, load_req, host_out_ready,
    input  load_gnt, host_out_valid, host_out_data, host_out_x, host_out_y,
           host_out_ch, driving_cons, stall_req, fifo_count, overflow
  );
endinterface

// File: rtl/con_bus_scheduler.sv
// Shares the host connection bus between inbound loads and outbound ODS words,
// buffering outbound words in a small FIFO and forcing an idle turnaround cycle.
module con_bus_scheduler #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 8,
  parameter int ALMOST_FULL_LVL = 6
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  con_bus_scheduler_if.master  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL_LVL);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [31:0]           x;
    logic [31:0]           y;
    logic [31:0]           ch;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  entry_t        wr_entry, head;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    state_q, state_d;
  logic          full, af, af_after, out_valid, push, pop;

  assign wr_entry = '{data: bus.wr_data, x: bus.wr_x, y: bus.wr_y, ch: bus.wr_ch};
  assign head     = mem_q[rptr_q];

  assign full      = (count_q == FULL_LVL);
  assign af        = (count_q >= AF_LVL);
  assign out_valid = (state_q == DRAIN) && (count_q != '0);
  assign pop       = out_valid && bus.host_out_ready;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the word.
  assign push      = bus.wr_valid && (!full || pop);

  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + AW'(1) : rptr_q;
    overflow_d = overflow_q | (bus.wr_valid & full & ~pop);
    af_after   = (count_d >= AF_LVL);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (af)                   state_d = DRAIN;
        else if (bus.load_req)    state_d = LOAD;
        else if (count_q != '0)   state_d = DRAIN;
      end
      LOAD: begin
        // Bursts are locked: only the controller releasing the request ends them.
        if (!bus.load_req)        state_d = IDLE;
      end
      DRAIN: begin
        if ((count_q == '0 && !push) || (pop && bus.load_req && !af_after))
          state_d = IDLE;
      end
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_entry;
  end

  assign bus.load_gnt       = (state_q == LOAD);
  assign bus.driving_cons   = (state_q == DRAIN);
  assign bus.host_out_valid = out_valid;
  assign bus.host_out_data  = head.data;
  assign bus.host_out_x     = head.x;
  assign bus.host_out_y     = head.y;
  assign bus.host_out_ch    = head.ch;
  assign bus.stall_req      = af;
  assign bus.fifo_count     = count_q;
  assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_con_bus_scheduler.sv
// Directed scenarios plus random traffic against a queue model of the FIFO and
// the bus ownership rules (lock, grant latency, turnaround, valid hold).
module tb_con_bus_scheduler;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic clk = 1'b0;
  logic arst_n_in = 1'b0;
  always #5 clk = ~clk;

  con_bus_scheduler_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus();

  con_bus_scheduler #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_LVL(AF)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .bus(bus)
  );

  typedef struct {
    logic [31:0] d, x, y, ch;
  } word_t;

  word_t q[$];
  bit    ov_exp;
  int    total, bad;
  bit    prev_ok, prev_vld, prev_rdy, prev_gnt, prev_req, prev_af;
  int    prev_dir;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dir_now();
    return bus.load_gnt ? 1 : (bus.driving_cons ? 2 : 0);
  endfunction

  task automatic check_outputs();
    int dir;
    dir = dir_now();
    chk("count",    64'(bus.fifo_count), 64'(q.size()));
    chk("overflow", 64'(bus.overflow),   64'(ov_exp));
    chk("stall",    64'(bus.stall_req),  64'(q.size() >= AF));
    chk("excl",     64'(bus.load_gnt & bus.driving_cons), 64'(0));
    chk("valid",    64'(bus.host_out_valid), 64'(bus.driving_cons && q.size() > 0));
    if (bus.host_out_valid && q.size() > 0) begin
      chk("head_d",  64'(bus.host_out_data), 64'(q[0].d));
      chk("head_x",  64'(bus.host_out_x),    64'(q[0].x));
      chk("head_y",  64'(bus.host_out_y),    64'(q[0].y));
      chk("head_ch", 64'(bus.host_out_ch),   64'(q[0].ch));
    end
    if (prev_ok) begin
      if (prev_dir != 0 && dir != 0) chk("turnaround", 64'(dir), 64'(prev_dir));
      if (prev_gnt) chk("gnt_lock", 64'(bus.load_gnt), 64'(prev_req));
      if (prev_dir == 0 && prev_req && !prev_af) chk("gnt_lat", 64'(bus.load_gnt), 64'(1));
      if (prev_vld && !prev_rdy) chk("vld_hold", 64'(bus.host_out_valid), 64'(1));
    end
  endtask

  task automatic model_update();
    bit    pop;
    word_t w;
    pop      = bus.host_out_valid && bus.host_out_ready;
    prev_vld = bus.host_out_valid;
    prev_rdy = bus.host_out_ready;
    prev_gnt = bus.load_gnt;
    prev_req = bus.load_req;
    prev_af  = (q.size() >= AF);
    prev_dir = dir_now();
    prev_ok  = 1'b1;
    if (pop && q.size() > 0) void'(q.pop_front());
    if (bus.wr_valid) begin
      w = '{d: bus.wr_data, x: bus.wr_x, y: bus.wr_y, ch: bus.wr_ch};
      if (q.size() < DEPTH) q.push_back(w);
      else ov_exp = 1'b1;
    end
  endtask

  task automatic step();
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input bit v, input logic [31:0] d, x, y, ch);
    bus.wr_valid = v;
    bus.wr_data  = d;
    bus.wr_x     = x;
    bus.wr_y     = y;
    bus.wr_ch    = ch;
  endtask

  task automatic drain_idle(input string tag);
    int n;
    n = 0;
    drive_wr(1'b0, 0, 0, 0, 0);
    bus.load_req       = 1'b0;
    bus.host_out_ready = 1'b1;
    while ((bus.driving_cons || q.size() > 0) && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_drain_bound"}, 64'(n < 40), 64'(1));
    chk({tag, "_drain_empty"}, 64'(bus.fifo_count), 64'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   64'(bus.load_gnt),       64'(0));
    chk({tag, "_drv"},   64'(bus.driving_cons),   64'(0));
    chk({tag, "_vld"},   64'(bus.host_out_valid), 64'(0));
    chk({tag, "_stall"}, 64'(bus.stall_req),      64'(0));
    chk({tag, "_ovf"},   64'(bus.overflow),       64'(0));
    chk({tag, "_cnt"},   64'(bus.fifo_count),     64'(0));
  endtask

  initial begin
    total = 0; bad = 0; ov_exp = 1'b0; prev_ok = 1'b0;
    prev_vld = 1'b0; prev_rdy = 1'b0; prev_gnt = 1'b0; prev_req = 1'b0;
    prev_af = 1'b0; prev_dir = 0;
    drive_wr(1'b0, 0, 0, 0, 0);
    bus.load_req = 1'b0;
    bus.host_out_ready = 1'b0;

    // Power-on reset
    #12;
    chk_all_zero("por");
    @(posedge clk); #1;
    arst_n_in = 1'b1;

    // Single word drain
    bus.host_out_ready = 1'b1;
    drive_wr(1'b1, 32'hA5, 32'd1, 32'd2, 32'd3);
    step();
    drive_wr(1'b0, 0, 0, 0, 0);
    chk("single_cnt1", 64'(bus.fifo_count), 64'(1));
    chk("single_vld0", 64'(bus.host_out_valid), 64'(0));
    step();
    chk("single_vld1", 64'(bus.host_out_valid), 64'(1));
    chk("single_data", 64'(bus.host_out_data), 64'(32'hA5));
    chk("single_x",    64'(bus.host_out_x),    64'(1));
    chk("single_y",    64'(bus.host_out_y),    64'(2));
    chk("single_ch",   64'(bus.host_out_ch),   64'(3));
    step();
    chk("single_popped", 64'(bus.fifo_count), 64'(0));
    chk("single_novld",  64'(bus.host_out_valid), 64'(0));
    step();
    chk("single_idle", 64'(bus.driving_cons), 64'(0));

    // Locked load with pushes reaching almost-full
    bus.load_req = 1'b1;
    step();
    chk("lock_gnt0", 64'(bus.load_gnt), 64'(1));
    for (int i = 0; i < 11; i++) begin
      drive_wr(i < 7, 32'h1000 + i, i, i + 1, i + 2);
      step();
      chk("lock_gnt", 64'(bus.load_gnt), 64'(1));
      if (i == 4) chk("lock_stall5", 64'(bus.stall_req), 64'(0));
      if (i == 5) begin
        chk("lock_cnt6",   64'(bus.fifo_count), 64'(6));
        chk("lock_stall6", 64'(bus.stall_req),  64'(1));
      end
    end
    drive_wr(1'b0, 0, 0, 0, 0);
    bus.load_req = 1'b0;
    step();
    chk("lock_rel_gnt", 64'(bus.load_gnt), 64'(0));
    chk("lock_rel_drv", 64'(bus.driving_cons), 64'(0));
    step();
    chk("lock_drain", 64'(bus.driving_cons), 64'(1));
    drain_idle("lock");

    // Interleave: a pending load gets the bus after one outbound word
    bus.host_out_ready = 1'b0;
    drive_wr(1'b1, 32'h2000, 7, 8, 9);
    step();
    drive_wr(1'b1, 32'h2001, 10, 11, 12);
    step();
    drive_wr(1'b0, 0, 0, 0, 0);
    chk("il_drv", 64'(bus.driving_cons), 64'(1));
    chk("il_cnt", 64'(bus.fifo_count), 64'(2));
    bus.load_req = 1'b1;
    bus.host_out_ready = 1'b1;
    step();
    chk("il_idle", 64'(bus.driving_cons | bus.load_gnt), 64'(0));
    chk("il_cnt1", 64'(bus.fifo_count), 64'(1));
    step();
    chk("il_load", 64'(bus.load_gnt), 64'(1));
    bus.load_req = 1'b0;
    step();
    drain_idle("il");

    // Full FIFO: simultaneous push/pop, then a dropped word
    bus.host_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_wr(1'b1, 32'd100 + i, i, i, i);
      step();
    end
    chk("full_cnt8", 64'(bus.fifo_count), 64'(8));
    chk("full_ovf0", 64'(bus.overflow), 64'(0));
    drive_wr(1'b1, 32'd200, 20, 20, 20);
    bus.host_out_ready = 1'b1;
    step();
    chk("pp_cnt8", 64'(bus.fifo_count), 64'(8));
    chk("pp_ovf0", 64'(bus.overflow), 64'(0));
    drive_wr(1'b1, 32'd300, 30, 30, 30);
    bus.host_out_ready = 1'b0;
    step();
    chk("ovf_set",   64'(bus.overflow), 64'(1));
    chk("ovf_cnt8",  64'(bus.fifo_count), 64'(8));
    chk("ovf_order", 64'(bus.host_out_data), 64'(101));
    drain_idle("ovf");
    chk("ovf_sticky", 64'(bus.overflow), 64'(1));

    // Asynchronous reset mid-drain with three words queued
    bus.host_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_wr(1'b1, 32'd400 + i, i, i, i);
      step();
    end
    drive_wr(1'b0, 0, 0, 0, 0);
    chk("rst_pre_drv", 64'(bus.driving_cons), 64'(1));
    chk("rst_pre_cnt", 64'(bus.fifo_count), 64'(3));
    #2;
    arst_n_in = 1'b0;
    #1;
    chk_all_zero("arst");
    q.delete();
    ov_exp = 1'b0;
    prev_ok = 1'b0;
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    step();
    chk("rst_post_cnt", 64'(bus.fifo_count), 64'(0));

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      drive_wr($urandom_range(0, 2) == 0, $urandom, $urandom, $urandom, $urandom);
      bus.host_out_ready = ((i % 200) < 150) ? ($urandom_range(0, 9) < 7) : 1'b0;
      if (bus.load_req) begin
        if (bus.load_gnt && $urandom_range(0, 5) == 0) bus.load_req = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        bus.load_req = 1'b1;
      end
      step();
    end
    drain_idle("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
